// File: rtl/instr_fetch_buffer.sv
// Fetch stage with a small prefetch FIFO: owns the fetch PC, fetches one ROM word
// per cycle and hands the oldest {pc, instr} to Decode over valid/ready.
module instr_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  output logic [31:0]              rom_address,
  input  logic [31:0]              rom_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_target,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              instr,
  output logic [31:0]              pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc_mem_d    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic          pop_s;
  logic          push_s;

  assign out_valid   = (count_q != {CW{1'b0}});
  assign rom_address = fetch_pc_q;
  assign count       = count_q;
  assign instr       = out_valid ? instr_mem_q[rd_ptr_q] : NOP;
  assign pc          = out_valid ? pc_mem_q[rd_ptr_q] : 32'h0000_0000;

  // Handshake qualifiers; a full queue still accepts a push when the head leaves.
  always_comb begin
    pop_s  = enable & out_valid & out_ready & ~redirect;
    push_s = enable & ~redirect & ((count_q < CW'(DEPTH)) | pop_s);
  end

  // Next-state for PC, pointers, occupancy and storage; redirect discards everything.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (enable && redirect) begin
      fetch_pc_d = {redirect_target[31:2], 2'b00};
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (push_s) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = rom_data;
        wr_ptr_d              = wr_ptr_q + AW'(1);
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CW'(1);
      end else if (pop_s && !push_s) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // State registers; reset empties the queue immediately without a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= 32'h0000_0000;
        instr_mem_q[i] <= NOP;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

endmodule
